ccff_bitstream_loader: RTL
==========================

# ccff_bitstream_loader

Drives the configuration-chain head (`ccff_head`) of a chain of tiles and watches the chain end (`ccff_tail`), making it the writing end of the serial configuration chain. It accepts bitstream words over a valid/ready interface and serialises exactly `CHAIN_LEN` bits into the chain. It qualifies each shift with an enable. In verify mode it streams the bitstream a second time and compares the bits returned on `ccff_tail`, which checks the loaded contents and the chain length together.

## Interface
- `WORD_W`, 32: bitstream word width.
- `CHAIN_LEN`, 1024: total configuration bits in the chain, ≥1.
- `CNT_W`, 16: bit and mismatch counter width; 2^CNT_W > CHAIN_LEN.
- `prog_clk` in 1: the only clock. All logic runs on the rising edge.
- `prog_reset` in 1: synchronous, active-high reset.
- `start` in 1: begins a load; sampled only in IDLE.
- `verify` in 1: sampled together with `start`. 1 selects a two-pass load with compare.
- `word_data` in WORD_W: bitstream word, transmitted LSB first.
- `word_valid` in 1: `word_data` is valid.
- `word_ready` out 1: loader accepts a word this cycle.
- `ccff_head` out 1: serial configuration bit into the chain.
- `ccff_shift_en` out 1: chain flops capture on this edge only when this is 1.
- `ccff_tail` in 1: last chain flop output.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse when a load completes.
- `error` out 1: sticky; at least one verify mismatch.
- `mismatch_cnt` out CNT_W: verify mismatch count, saturating.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `start`=1 → LOAD.
  - Latch `verify` into `pass_max` (0: one pass; 1: two passes).
  - Clear `error`, `mismatch_cnt`, `pass`, `bit_idx`.
- LOAD:
  - `word_ready`=1.
  - On `word_valid`&&`word_ready`: load `word_data` into the shift register. Set `nbits = min(WORD_W, CHAIN_LEN − bit_idx)`, then → SHIFT.
  - While `word_valid`=0, stay in LOAD; the chain holds.
- SHIFT:
  - Every cycle: `ccff_shift_en`=1, `ccff_head`=sr[0], shift sr right, `bit_idx`++.
  - Word bits above `nbits` are discarded.
  - After `nbits` cycles: if `bit_idx`=CHAIN_LEN, go to end-of-pass handling; else → LOAD.
- End of pass:
  - If `pass`<`pass_max`: `pass`++, `bit_idx`=0, → LOAD. The host restarts from word 0.
  - Otherwise → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Verify compare:
  - In pass 1, every SHIFT cycle compares `ccff_tail` with `ccff_head`.
  - The tail returns the bit shifted CHAIN_LEN enabled edges earlier, which is the same bit position from pass 0.
  - On a mismatch, `error` is set and `mismatch_cnt` increments, saturating at all-ones.
  - Pass 0 never compares.
- Bit order: first bit shifted ends deepest in the chain; bit 0 of word 0 emerges first on `ccff_tail`.
- `start` while `busy` is ignored. `verify` outside IDLE is ignored.
- `busy`=1 in LOAD and SHIFT.

## Timing
- Reset values: state IDLE, `word_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `error`=0, `mismatch_cnt`=0.
- All outputs except `word_ready` are decoded from registers with no input-to-output path. `word_ready` is state-decoded.
- `start` at cycle t gives LOAD at t+1.
- A handshake at cycle t gives first shift at t+1 with `ccff_head`=word[0].
- Each full word costs WORD_W+1 cycles: one LOAD bubble where `ccff_shift_en`=0.
- Last shift of the final pass at cycle t gives `done` at t+1 and `busy`=0 at t+1.
- `prog_reset` mid-load: state goes to IDLE next edge and `ccff_shift_en` drops immediately. The chain keeps the partial contents; a new `start` reloads from bit 0.
- Final partial word (CHAIN_LEN mod WORD_W ≠ 0): only the low bits are shifted.
- CHAIN_LEN < WORD_W: one word per pass.

## Test plan
- **Basic load.** WORD_W=32, CHAIN_LEN=40, verify=0, `start` at cycle 0, words always valid.
  - Word accepted cycle 1; shifts cycles 2–33; LOAD cycle 34; shifts 35–42; `done` at 43.
  - Exactly 40 `ccff_shift_en` pulses; a 40-bit chain model holds the expected bits.
- **Stall.** Drop `word_valid` for 5 cycles before word 1.
  - `ccff_shift_en`=0 throughout the gap; `done` is 5 cycles later than in basic load; chain contents unchanged.
- **Verify pass.** verify=1 with a correct 40-bit chain model, words 0xA5A5_5A5A, 0x0000_00C3 in each pass.
  - 80 shifts; `done` pulses; `error`=0; `mismatch_cnt`=0.
- **Chain-length fault.** verify=1 with a 39-bit chain model, same data.
  - `error`=1 and `mismatch_cnt`>0 at `done`.
- **Reset mid-load.** Assert `prog_reset` at cycle 10 of a load.
  - Next cycle: `busy`=0, `ccff_shift_en`=0. A new `start` completes a full 40-shift load.
- **Ignored start.** Pulse `start` while `busy`=1.
  - Load is unaffected; exactly one `done` pulse.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Serial configuration-chain writer: streams CHAIN_LEN bits from valid/ready words into ccff_head,
// optionally repeating the stream and comparing what returns on ccff_tail.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  mismatch_cnt
);
  localparam int NB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [NB_W-1:0]    cnt_q, cnt_d;
  logic               pass_q, pass_d;
  logic               pass_max_q, pass_max_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   mm_q, mm_d;
  logic [CNT_W-1:0]   rem;

  assign rem = CNT_W'(CHAIN_LEN) - bit_idx_q;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      pass_max_q <= 1'b0;
      err_q      <= 1'b0;
      mm_q       <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      pass_max_q <= pass_max_d;
      err_q      <= err_d;
      mm_q       <= mm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    pass_max_d = pass_max_q;
    err_d      = err_q;
    mm_d       = mm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          pass_max_d = verify;
          pass_d     = 1'b0;
          bit_idx_d  = '0;
          err_d      = 1'b0;
          mm_d       = '0;
        end
      end
      LOAD: begin
        if (word_valid) begin
          sr_d    = word_data;
          cnt_d   = (rem < CNT_W'(WORD_W)) ? NB_W'(rem) : NB_W'(WORD_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d      = {1'b0, sr_q[WORD_W-1:1]};
        bit_idx_d = bit_idx_q + 1'b1;
        cnt_d     = cnt_q - 1'b1;
        // Tail now carries the bit driven CHAIN_LEN shifts ago: same position, previous pass.
        if (pass_q && (ccff_tail != sr_q[0])) begin
          err_d = 1'b1;
          if (mm_q != '1) mm_d = mm_q + 1'b1;
        end
        if (cnt_q == NB_W'(1)) begin
          if (bit_idx_d == CNT_W'(CHAIN_LEN)) begin
            if (pass_q < pass_max_q) begin
              pass_d    = 1'b1;
              bit_idx_d = '0;
              state_d   = LOAD;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign word_ready    = (state_q == LOAD);
  assign ccff_shift_en = (state_q == SHIFT);
  assign ccff_head     = ccff_shift_en & sr_q[0];
  assign busy          = (state_q == LOAD) || (state_q == SHIFT);
  assign done          = (state_q == DONE);
  assign error         = err_q;
  assign mismatch_cnt  = mm_q;

endmodule
